// File: rtl/spi_job_loader_pkg.sv
// Shared constants and FSM encodings for the SPI job loader.
package spi_job_loader_pkg;

  localparam int unsigned MIDSTATE_BITS    = 256;
  localparam int unsigned HEADER_TAIL_BITS = 96;
  localparam int unsigned JOB_BITS         = MIDSTATE_BITS + HEADER_TAIL_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous SPI line with edge detect.
// level is stage 1; edges compare stage 1 against stage 2.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic async_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [2:0] sync_q;

  // Shift the asynchronous input through three flops; reset to idle level
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign level  = sync_q[1];
  assign rise_c = ~sync_q[2] &  sync_q[1];
  assign fall_c =  sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/spi_job_loader.sv
// SPI slave that receives fixed-length mining jobs and hands them to a
// valid/ready consumer, flagging short/long frames and dropped jobs.
module spi_job_loader #(
  parameter int unsigned JOB_BITS = spi_job_loader_pkg::JOB_BITS
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                sck_in,
  input  logic                sdi_in,
  input  logic                cs_n_in,
  output logic                sdo_out,
  output logic [JOB_BITS-1:0] job_data_out,
  output logic                job_valid_out,
  input  logic                job_ready_in,
  output logic                frame_error_out,
  output logic                overrun_out,
  output logic                busy_out
);

  import spi_job_loader_pkg::*;

  localparam int unsigned CNT_W = $clog2(JOB_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(JOB_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(JOB_BITS + 1);

  rx_state_t           state;
  logic [JOB_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [1:0]          settle_cnt;
  logic                armed;

  logic sck_rise;
  logic sck_level_unused;
  logic sck_fall_unused;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic sdi_level;
  logic sdi_rise_unused;
  logic sdi_fall_unused;
  logic shift_en;
  logic handshake;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .async_in (sck_in),
    .level    (sck_level_unused),
    .rise_c   (sck_rise),
    .fall_c   (sck_fall_unused)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .async_in (cs_n_in),
    .level    (cs_level),
    .rise_c   (cs_rise),
    .fall_c   (cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sdi_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .async_in (sdi_in),
    .level    (sdi_level),
    .rise_c   (sdi_rise_unused),
    .fall_c   (sdi_fall_unused)
  );

  assign shift_en  = sck_rise & ~cs_level;
  assign handshake = job_valid_out & job_ready_in;

  // Receiver FSM, shift path, commit/handshake logic and status pulses.
  // A cs that is already low at reset release would look like a falling
  // edge (sync flops reset high), so frames are only accepted once cs has
  // been observed high after the synchronizer has settled.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state           <= ST_IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      settle_cnt      <= '0;
      armed           <= 1'b0;
      sdo_out         <= 1'b0;
      job_data_out    <= '0;
      job_valid_out   <= 1'b0;
      frame_error_out <= 1'b0;
      overrun_out     <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      frame_error_out <= 1'b0;
      overrun_out     <= 1'b0;

      if (settle_cnt != 2'd2) begin
        settle_cnt <= settle_cnt + 2'd1;
      end else if (cs_level) begin
        armed <= 1'b1;
      end

      if (shift_en) begin
        shift_reg <= {shift_reg[JOB_BITS-2:0], sdi_level};
        sdo_out   <= shift_reg[JOB_BITS-2];
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      if (handshake) begin
        job_valid_out <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall && armed) begin
            state    <= ST_RECV;
            busy_out <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        ST_RECV: begin
          if (cs_rise) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
          if (bit_cnt == CNT_FULL) begin
            if (!job_valid_out || job_ready_in) begin
              job_data_out  <= shift_reg;
              job_valid_out <= 1'b1;
            end else begin
              overrun_out <= 1'b1;
            end
          end else if (bit_cnt != '0) begin
            frame_error_out <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_job_loader.sv
// Directed bench for spi_job_loader: frames, overrun, length errors,
// empty frames, reset mid-frame and same-cycle handshake on commit.
module tb_spi_job_loader;

  localparam int unsigned JB = 352;

  logic          clk;
  logic          reset_in;
  logic          sck_in;
  logic          sdi_in;
  logic          cs_n_in;
  logic          sdo_out;
  logic [JB-1:0] job_data_out;
  logic          job_valid_out;
  logic          job_ready_in;
  logic          frame_error_out;
  logic          overrun_out;
  logic          busy_out;

  int checks = 0;
  int passed = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;

  logic [JB-1:0] exp_a5;
  logic [JB-1:0] exp_3c;
  logic [JB-1:0] exp_c3;

  spi_job_loader dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .sck_in          (sck_in),
    .sdi_in          (sdi_in),
    .cs_n_in         (cs_n_in),
    .sdo_out         (sdo_out),
    .job_data_out    (job_data_out),
    .job_valid_out   (job_valid_out),
    .job_ready_in    (job_ready_in),
    .frame_error_out (frame_error_out),
    .overrun_out     (overrun_out),
    .busy_out        (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one-cycle status pulses
  always @(negedge clk) begin
    if (frame_error_out === 1'b1) err_cnt++;
    if (overrun_out === 1'b1) ovr_cnt++;
  end

  task automatic shift_bits(input int n, input logic [7:0] pat);
    for (int i = n - 1; i >= 0; i--) begin
      sdi_in = pat[i % 8];
      repeat (2) @(negedge clk);
      sck_in = 1'b1;
      repeat (4) @(negedge clk);
      sck_in = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] pat);
    cs_n_in = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(n, pat);
    repeat (4) @(negedge clk);
    cs_n_in = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (job_valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", job_valid_out); else passed++;
    checks++; if (job_data_out !== '0) $display("FAIL reset_data: got %h expected 0", job_data_out); else passed++;
    checks++; if (frame_error_out !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_error_out); else passed++;
    checks++; if (overrun_out !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", overrun_out); else passed++;
    checks++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_out); else passed++;
    checks++; if (sdo_out !== 1'b0) $display("FAIL reset_sdo: got %b expected 0", sdo_out); else passed++;
    reset_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int e0;
    e0 = err_cnt;
    send_frame(352, 8'hA5);
    checks++; if (job_valid_out !== 1'b1) $display("FAIL single_valid: got %b expected 1", job_valid_out); else passed++;
    checks++; if (job_data_out !== exp_a5) $display("FAIL single_data: got %h expected %h", job_data_out, exp_a5); else passed++;
    checks++; if (err_cnt !== e0) $display("FAIL single_ferr: got %0d pulses expected %0d", err_cnt, e0); else passed++;
    checks++; if (sdo_out !== 1'b1) $display("FAIL single_sdo: got %b expected 1", sdo_out); else passed++;
    checks++; if (busy_out !== 1'b0) $display("FAIL single_busy: got %b expected 0", busy_out); else passed++;
  endtask

  task automatic test_overrun();
    int o0;
    int e0;
    o0 = ovr_cnt;
    e0 = err_cnt;
    send_frame(352, 8'h5A);
    checks++; if (ovr_cnt !== o0 + 1) $display("FAIL ovr_pulse: got %0d pulses expected %0d", ovr_cnt, o0 + 1); else passed++;
    checks++; if (job_data_out !== exp_a5) $display("FAIL ovr_data: got %h expected %h", job_data_out, exp_a5); else passed++;
    checks++; if (job_valid_out !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", job_valid_out); else passed++;
    checks++; if (sdo_out !== 1'b0) $display("FAIL ovr_sdo: got %b expected 0", sdo_out); else passed++;
    checks++; if (err_cnt !== e0) $display("FAIL ovr_ferr: got %0d pulses expected %0d", err_cnt, e0); else passed++;
    job_ready_in = 1'b1;
    @(negedge clk);
    job_ready_in = 1'b0;
    checks++; if (job_valid_out !== 1'b0) $display("FAIL ovr_accept: got %b expected 0", job_valid_out); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty_frame();
    int e0;
    int o0;
    e0 = err_cnt;
    o0 = ovr_cnt;
    sdi_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sck_in = 1'b1;
      repeat (4) @(negedge clk);
      sck_in = 1'b0;
      repeat (4) @(negedge clk);
    end
    checks++; if (sdo_out !== 1'b0) $display("FAIL cs_high_sck: got %b expected 0", sdo_out); else passed++;
    cs_n_in = 1'b0;
    repeat (10) @(negedge clk);
    cs_n_in = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (err_cnt !== e0) $display("FAIL empty_ferr: got %0d expected %0d", err_cnt, e0); else passed++;
    checks++; if (ovr_cnt !== o0) $display("FAIL empty_ovr: got %0d expected %0d", ovr_cnt, o0); else passed++;
    checks++; if (busy_out !== 1'b0) $display("FAIL empty_busy: got %b expected 0", busy_out); else passed++;
    checks++; if (job_valid_out !== 1'b0) $display("FAIL empty_valid: got %b expected 0", job_valid_out); else passed++;
    checks++; if (job_data_out !== exp_a5) $display("FAIL empty_data: got %h expected %h", job_data_out, exp_a5); else passed++;
  endtask

  task automatic test_bad_length();
    int e0;
    int o0;
    e0 = err_cnt;
    o0 = ovr_cnt;
    job_ready_in = 1'b1;
    send_frame(351, 8'h11);
    checks++; if (err_cnt !== e0 + 1) $display("FAIL short_ferr: got %0d expected %0d", err_cnt, e0 + 1); else passed++;
    checks++; if (job_valid_out !== 1'b0) $display("FAIL short_valid: got %b expected 0", job_valid_out); else passed++;
    send_frame(353, 8'h11);
    checks++; if (err_cnt !== e0 + 2) $display("FAIL long_ferr: got %0d expected %0d", err_cnt, e0 + 2); else passed++;
    checks++; if (job_valid_out !== 1'b0) $display("FAIL long_valid: got %b expected 0", job_valid_out); else passed++;
    checks++; if (ovr_cnt !== o0) $display("FAIL badlen_ovr: got %0d expected %0d", ovr_cnt, o0); else passed++;
    job_ready_in = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    cs_n_in = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(200, 8'h3C);
    reset_in = 1'b1;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);
    checks++; if (job_valid_out !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", job_valid_out); else passed++;
    checks++; if (job_data_out !== '0) $display("FAIL midrst_data: got %h expected 0", job_data_out); else passed++;
    repeat (10) @(negedge clk);
    checks++; if (busy_out !== 1'b0) $display("FAIL midrst_idle: got %b expected 0", busy_out); else passed++;
    cs_n_in = 1'b1;
    repeat (10) @(negedge clk);
    e0 = err_cnt;
    send_frame(352, 8'h3C);
    checks++; if (job_data_out !== exp_3c) $display("FAIL midrst_newdata: got %h expected %h", job_data_out, exp_3c); else passed++;
    checks++; if (job_valid_out !== 1'b1) $display("FAIL midrst_newvalid: got %b expected 1", job_valid_out); else passed++;
    checks++; if (err_cnt !== e0) $display("FAIL midrst_ferr: got %0d expected %0d", err_cnt, e0); else passed++;
  endtask

  task automatic test_back_to_back();
    int o0;
    int e0;
    o0 = ovr_cnt;
    e0 = err_cnt;
    cs_n_in = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(352, 8'hC3);
    repeat (4) @(negedge clk);
    cs_n_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy_out !== 1'b1) $display("FAIL b2b_commit_busy: got %b expected 1", busy_out); else passed++;
    checks++; if (job_valid_out !== 1'b1) $display("FAIL b2b_pending: got %b expected 1", job_valid_out); else passed++;
    job_ready_in = 1'b1;
    @(negedge clk);
    job_ready_in = 1'b0;
    checks++; if (job_valid_out !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", job_valid_out); else passed++;
    checks++; if (job_data_out !== exp_c3) $display("FAIL b2b_data: got %h expected %h", job_data_out, exp_c3); else passed++;
    checks++; if (busy_out !== 1'b0) $display("FAIL b2b_busy: got %b expected 0", busy_out); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (ovr_cnt !== o0) $display("FAIL b2b_ovr: got %0d expected %0d", ovr_cnt, o0); else passed++;
    checks++; if (err_cnt !== e0) $display("FAIL b2b_ferr: got %0d expected %0d", err_cnt, e0); else passed++;
  endtask

  initial begin
    exp_a5       = {44{8'hA5}};
    exp_3c       = {44{8'h3C}};
    exp_c3       = {44{8'hC3}};
    reset_in     = 1'b1;
    sck_in       = 1'b0;
    sdi_in       = 1'b0;
    cs_n_in      = 1'b1;
    job_ready_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_overrun();
    test_empty_frame();
    test_bad_length();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_job_loader.md
SPI_JOB_LOADER -- requirements
Module: spi_job_loader

Interface
REQ-001 Parameter JOB_BITS, default 352, means the exact frame length in bits (256-bit midstate + 96-bit header tail).
REQ-002 clk_in  input  1  sole clock; all logic is on its rising edge.
REQ-003 reset_in  input  1  reset; synchronous, active-high.
REQ-004 sck_in  input  1  SPI clock from host, asynchronous to clk_in.
REQ-005 sdi_in  input  1  SPI data in, MSB first, sampled on rising sck.
REQ-006 cs_n_in  input  1  SPI chip select, active-low, asynchronous.
REQ-007 sdo_out  output  1  daisy passthrough: MSB of the shift register.
REQ-008 job_data_out  output  JOB_BITS  last committed job, stable while job_valid_out is high.
REQ-009 job_valid_out  output  1  committed job awaiting consumer.
REQ-010 job_ready_in  input  1  consumer accepts the job when high together with job_valid_out.
REQ-011 frame_error_out  output  1  one-cycle pulse: frame length not equal to JOB_BITS.
REQ-012 overrun_out  output  1  one-cycle pulse: valid frame dropped because a job was pending.
REQ-013 busy_out  output  1  high while the receiver is not IDLE.

Function
REQ-014 sck_in, sdi_in and cs_n_in shall each pass through a 3-flop synchronizer (stages s[0..2]).
REQ-015 sck rise = ~sck_s[2] & sck_s[1]; cs fall = cs_s[2] & ~cs_s[1]; cs rise = ~cs_s[2] & cs_s[1].
REQ-016 On sck rise with cs_s[1] low, the shift register shall shift left and take sdi_s[1] into the LSB.
REQ-017 Bit counter width clog2(JOB_BITS+2); it increments per shifted bit and saturates at JOB_BITS+1.
REQ-018 Receiver FSM states: IDLE, RECV, COMMIT.
REQ-019 IDLE -> RECV on cs fall; the bit counter clears in the same cycle.
REQ-020 RECV -> COMMIT on cs rise; COMMIT -> IDLE unconditionally after one cycle.
REQ-021 In COMMIT with count == JOB_BITS and job_valid_out low: job_data_out <= shift register and job_valid_out <= 1, visible the cycle after COMMIT.
REQ-022 In COMMIT with count == JOB_BITS and job_valid_out high (and no handshake that cycle): frame dropped, overrun_out pulses, job_data_out unchanged.
REQ-023 In COMMIT with count == JOB_BITS and a handshake in the same cycle: the new job loads and job_valid_out stays high.
REQ-024 In COMMIT with 0 < count != JOB_BITS: frame_error_out pulses; job outputs unchanged.
REQ-025 In COMMIT with count == 0: no error and no commit (silent).
REQ-026 job_valid_out clears on the cycle after job_valid_out & job_ready_in.
REQ-027 job_ready_in while job_valid_out is low shall have no effect.
REQ-028 sck rises while cs_s[1] is high shall be ignored.
REQ-029 A cs fall seen in COMMIT shall be handled in the next cycle in IDLE (2-cycle sync latency absorbs it).
REQ-030 sdo_out shall be the shift register MSB, registered, updated only by shifts.

Reset
REQ-031 reset_in high: FSM -> IDLE, counter = 0, shift register = 0, job_data_out = 0, job_valid_out = 0.
REQ-032 reset_in high: frame_error_out = 0, overrun_out = 0, busy_out = 0, sdo_out = 0.
REQ-033 Synchronizer flops reset to idle levels: sck 0, sdi 0, cs 1.
REQ-034 Reset mid-frame abandons the frame; bits before release are discarded.
REQ-035 After reset, a frame needs a fresh cs fall; a cs still low at release stays in IDLE until cs rises and falls again.

Structure
REQ-036 JOB_BITS, MIDSTATE_BITS (256) and HEADER_TAIL_BITS (96) shall live in the shared constants package.
REQ-037 FSM state encodings shall live in the shared constants package.
REQ-038 One sub-module, spi_sync_edge: a 3-flop synchronizer with rise/fall outputs, instantiated for sck and cs; sdi uses its stage output.

Verification
REQ-039 Reset, then shift 352 bits of 0xA5 repeating -> job_valid_out = 1; job_data_out = {44{8'hA5}}; frame_error_out never pulses.
REQ-040 Valid job pending, hold job_ready_in low, send a second 352-bit frame -> overrun_out pulses once; job_data_out unchanged; ready high -> valid drops next cycle.
REQ-041 Send 351 bits, then 353 bits -> frame_error_out pulses once per frame; job_valid_out stays 0.
REQ-042 cs low then high with no sck edges -> no pulses; FSM returns to IDLE; job outputs unchanged.
REQ-043 Assert reset_in after 200 bits of a frame, release, send a full 352-bit frame of 0x3C -> job_data_out = {44{8'h3C}}, no frame_error_out.
REQ-044 Pending job; ready asserted in the same cycle a new valid frame commits -> new data loads, job_valid_out stays 1, no overrun_out.
